fir_sched: RTL and testbench

FIR_SCHED -- requirements
Module: fir_sched

---
 rtl/fir_sched_pkg.sv | 36 +++
 rtl/fir_axil_master.sv | 112 +++++++++++
 rtl/fir_sched.sv | 240 ++++++++++++++++++++++++
 tb/tb_fir_sched.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_sched_pkg.sv
// ============================================================================
// Module      : fir_sched_pkg
// Description : Shared FIR register map, ap_ctrl bit positions and scheduler
//               state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fir_sched_pkg;

    localparam int unsigned c_ofs_ctrl = 32'h00;
    localparam int unsigned c_ofs_len  = 32'h10;
    localparam int unsigned c_ofs_tap  = 32'h40;

    localparam int c_bit_start = 0;
    localparam int c_bit_done  = 1;
    localparam int c_bit_idle  = 2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CHK_IDLE  = 3'd1,
        ST_WR_LEN    = 3'd2,
        ST_WR_TAP    = 3'd3,
        ST_WR_START  = 3'd4,
        ST_STREAM    = 3'd5,
        ST_WAIT_DONE = 3'd6,
        ST_DONE      = 3'd7
    } fir_state_e;

    function automatic int unsigned tap_offset(input int unsigned idx);
        return c_ofs_tap + 4 * idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fir_axil_master.sv
// ============================================================================
// Module      : fir_axil_master
// Description : Single-beat AXI-Lite master; one read or write per req pulse,
//               done pulses one cycle after the last handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir_axil_master
    import fir_sched_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  axis_clk,
    input  logic                  axis_rst_n,
    input  logic                  req,
    input  logic                  wr,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] m_awaddr,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic [DATA_WIDTH-1:0] m_wdata,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    output logic [ADDR_WIDTH-1:0] m_araddr,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic                  m_rvalid,
    output logic                  m_rready
);

    logic                  r_busy;
    logic                  r_wr_op;
    logic                  r_aw_pend;
    logic                  r_w_pend;
    logic                  r_ar_pend;
    logic                  r_r_pend;
    logic                  r_done;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  w_aw_left;
    logic                  w_w_left;

    // Address and data channels retire independently; the write ends when both have.
    assign w_aw_left = r_aw_pend & ~m_awready;
    assign w_w_left  = r_w_pend  & ~m_wready;

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            r_busy    <= 1'b0;
            r_wr_op   <= 1'b0;
            r_aw_pend <= 1'b0;
            r_w_pend  <= 1'b0;
            r_ar_pend <= 1'b0;
            r_r_pend  <= 1'b0;
            r_done    <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
            r_rdata   <= '0;
        end else begin
            r_done <= 1'b0;
            if (!r_busy) begin
                if (req) begin
                    r_busy    <= 1'b1;
                    r_wr_op   <= wr;
                    r_addr    <= addr;
                    r_data    <= wr ? data : '0;
                    r_aw_pend <= wr;
                    r_w_pend  <= wr;
                    r_ar_pend <= ~wr;
                end
            end else if (r_wr_op) begin
                r_aw_pend <= w_aw_left;
                r_w_pend  <= w_w_left;
                if (!w_aw_left && !w_w_left) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end else begin
                if (r_ar_pend && m_arready) begin
                    r_ar_pend <= 1'b0;
                    r_r_pend  <= 1'b1;
                end
                if (r_r_pend && m_rvalid) begin
                    r_r_pend <= 1'b0;
                    r_rdata  <= m_rdata;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b1;
                end
            end
        end
    end

    assign m_awvalid = r_aw_pend;
    assign m_awaddr  = r_aw_pend ? r_addr : '0;
    assign m_wvalid  = r_w_pend;
    assign m_wdata   = r_w_pend ? r_data : '0;
    assign m_arvalid = r_ar_pend;
    assign m_araddr  = r_ar_pend ? r_addr : '0;
    assign m_rready  = r_r_pend;
    assign done      = r_done;
    assign rdata     = r_rdata;

endmodule

`default_nettype wire

// File: rtl/fir_sched.sv
// ============================================================================
// Module      : fir_sched
// Description : Job scheduler for an AXI-Lite/AXI-Stream FIR: programs length
//               and taps, starts the core, streams samples and waits for done.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir_sched
    import fir_sched_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int NUM_TAP    = 11
) (
    input  logic                         axis_clk,
    input  logic                         axis_rst_n,
    input  logic                         cmd_start,
    input  logic [31:0]                  cmd_len,
    output logic                         cmd_busy,
    output logic                         cmd_done,
    output logic                         cmd_err,
    output logic [$clog2(NUM_TAP)-1:0]   coef_addr,
    input  logic [DATA_WIDTH-1:0]        coef_data,
    output logic [ADDR_WIDTH-1:0]        awaddr,
    output logic                         awvalid,
    input  logic                         awready,
    output logic [DATA_WIDTH-1:0]        wdata,
    output logic                         wvalid,
    input  logic                         wready,
    output logic [ADDR_WIDTH-1:0]        araddr,
    output logic                         arvalid,
    input  logic                         arready,
    input  logic [DATA_WIDTH-1:0]        rdata,
    input  logic                         rvalid,
    output logic                         rready,
    input  logic                         src_tvalid,
    input  logic [DATA_WIDTH-1:0]        src_tdata,
    output logic                         src_tready,
    output logic                         ss_tvalid,
    output logic [DATA_WIDTH-1:0]        ss_tdata,
    output logic                         ss_tlast,
    input  logic                         ss_tready,
    input  logic                         sm_tvalid,
    input  logic [DATA_WIDTH-1:0]        sm_tdata,
    input  logic                         sm_tlast,
    output logic                         sm_tready,
    output logic                         dst_tvalid,
    output logic [DATA_WIDTH-1:0]        dst_tdata,
    output logic                         dst_tlast,
    input  logic                         dst_tready
);

    localparam int TAP_W = $clog2(NUM_TAP);

    fir_state_e            r_state;
    fir_state_e            w_state_nxt;
    logic [31:0]           r_len;
    logic [31:0]           r_in_cnt;
    logic [31:0]           r_out_cnt;
    logic [TAP_W-1:0]      r_tap;
    logic                  r_inflight;
    logic                  r_err;
    logic                  w_bus_state;
    logic                  w_req;
    logic                  w_wr;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  w_mdone;
    logic [DATA_WIDTH-1:0] w_mrdata;
    logic                  w_in_act;
    logic                  w_out_act;
    logic                  w_unused;

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_bus_state = 1'b0;
        w_wr        = 1'b0;
        w_addr      = '0;
        w_data      = '0;
        case (r_state)
            ST_IDLE: begin
                if (cmd_start && (cmd_len != 32'd0)) begin
                    w_state_nxt = ST_CHK_IDLE;
                end
            end
            ST_CHK_IDLE: begin
                w_bus_state = 1'b1;
                w_addr      = ADDR_WIDTH'(c_ofs_ctrl);
                if (w_mdone && w_mrdata[c_bit_idle]) begin
                    w_state_nxt = ST_WR_LEN;
                end
            end
            ST_WR_LEN: begin
                w_bus_state = 1'b1;
                w_wr        = 1'b1;
                w_addr      = ADDR_WIDTH'(c_ofs_len);
                w_data      = DATA_WIDTH'(r_len);
                if (w_mdone) begin
                    w_state_nxt = ST_WR_TAP;
                end
            end
            ST_WR_TAP: begin
                w_bus_state = 1'b1;
                w_wr        = 1'b1;
                w_addr      = ADDR_WIDTH'(tap_offset(32'(r_tap)));
                w_data      = coef_data;
                if (w_mdone && (r_tap == TAP_W'(NUM_TAP - 1))) begin
                    w_state_nxt = ST_WR_START;
                end
            end
            ST_WR_START: begin
                w_bus_state         = 1'b1;
                w_wr                = 1'b1;
                w_addr              = ADDR_WIDTH'(c_ofs_ctrl);
                w_data[c_bit_start] = 1'b1;
                if (w_mdone) begin
                    w_state_nxt = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if ((r_in_cnt == r_len) && (r_out_cnt == r_len)) begin
                    w_state_nxt = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                w_bus_state = 1'b1;
                w_addr      = ADDR_WIDTH'(c_ofs_ctrl);
                if (w_mdone && w_mrdata[c_bit_done]) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // One request per bus transaction: re-armed the cycle after the master reports done.
    assign w_req = w_bus_state & ~r_inflight;

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            r_len      <= 32'd0;
            r_in_cnt   <= 32'd0;
            r_out_cnt  <= 32'd0;
            r_tap      <= '0;
            r_inflight <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if ((r_state == ST_IDLE) && cmd_start) begin
                if (cmd_len == 32'd0) begin
                    r_err <= 1'b1;
                end else begin
                    r_len     <= cmd_len;
                    r_in_cnt  <= 32'd0;
                    r_out_cnt <= 32'd0;
                end
            end
            if (ss_tvalid && ss_tready) begin
                r_in_cnt <= r_in_cnt + 32'd1;
            end
            if (dst_tvalid && dst_tready) begin
                r_out_cnt <= r_out_cnt + 32'd1;
            end
            if (w_req) begin
                r_inflight <= 1'b1;
            end else if (w_mdone) begin
                r_inflight <= 1'b0;
            end
            if (r_state == ST_WR_LEN) begin
                r_tap <= '0;
            end else if ((r_state == ST_WR_TAP) && w_mdone) begin
                r_tap <= r_tap + TAP_W'(1);
            end
        end
    end

    fir_axil_master #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_axil_master (
        .axis_clk   (axis_clk),
        .axis_rst_n (axis_rst_n),
        .req        (w_req),
        .wr         (w_wr),
        .addr       (w_addr),
        .data       (w_data),
        .done       (w_mdone),
        .rdata      (w_mrdata),
        .m_awaddr   (awaddr),
        .m_awvalid  (awvalid),
        .m_awready  (awready),
        .m_wdata    (wdata),
        .m_wvalid   (wvalid),
        .m_wready   (wready),
        .m_araddr   (araddr),
        .m_arvalid  (arvalid),
        .m_arready  (arready),
        .m_rdata    (rdata),
        .m_rvalid   (rvalid),
        .m_rready   (rready)
    );

    assign w_in_act  = (r_state == ST_STREAM) && (r_in_cnt < r_len);
    assign w_out_act = (r_state == ST_STREAM) && (r_out_cnt < r_len);

    assign ss_tvalid  = w_in_act & src_tvalid;
    assign ss_tdata   = ss_tvalid ? src_tdata : '0;
    assign ss_tlast   = ss_tvalid && (r_in_cnt == r_len - 32'd1);
    assign src_tready = w_in_act & ss_tready;

    // The core's own tlast is not trusted; framing comes from the output count.
    assign dst_tvalid = w_out_act & sm_tvalid;
    assign dst_tdata  = dst_tvalid ? sm_tdata : '0;
    assign dst_tlast  = dst_tvalid && (r_out_cnt == r_len - 32'd1);
    assign sm_tready  = w_out_act & dst_tready;

    assign cmd_busy  = (r_state != ST_IDLE);
    assign cmd_done  = (r_state == ST_DONE);
    assign cmd_err   = r_err;
    assign coef_addr = (r_state == ST_WR_TAP) ? r_tap : '0;

    assign w_unused = ^{sm_tlast, w_mrdata};

endmodule

`default_nettype wire

// File: tb/tb_fir_sched.sv
// ============================================================================
// Module      : tb_fir_sched
// Description : Directed bench for fir_sched with AXI-Lite slave and FIR
//               stream models.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fir_sched;

    localparam int AW_DELAY = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_start = 1'b0;
    logic [31:0] cmd_len = 32'd0;
    logic        cmd_busy, cmd_done, cmd_err;
    logic [3:0]  coef_addr;
    logic [31:0] coef_data;
    logic [11:0] awaddr, araddr;
    logic        awvalid, wvalid, arvalid, rready;
    logic        awready = 1'b0, wready = 1'b0, arready = 1'b0, rvalid = 1'b0;
    logic [31:0] wdata;
    logic [31:0] rdata = 32'd0;
    logic        src_tvalid = 1'b0, ss_tready = 1'b0, sm_tvalid = 1'b0, sm_tlast = 1'b0, dst_tready = 1'b0;
    logic [31:0] src_tdata = 32'd0, sm_tdata = 32'd0;
    logic        src_tready, ss_tvalid, ss_tlast, sm_tready, dst_tvalid, dst_tlast;
    logic [31:0] ss_tdata, dst_tdata;

    int errors = 0;
    int checks = 0;

    int cfg_idle_busy = 0;
    int cfg_done_busy = 0;
    int cfg_src_n     = 0;

    logic [11:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [11:0] rd_addr_q[$];
    int          rd_before_wr;
    logic [31:0] ss_q[$];
    logic [31:0] dst_q[$];
    int          ss_last_mask, dst_last_mask;
    int          done_cnt, err_cnt;
    logic        bus_seen;

    assign coef_data = 32'h100 + {28'd0, coef_addr};

    always #5 clk = ~clk;

    fir_sched #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .NUM_TAP(11)) dut (
        .axis_clk(clk), .axis_rst_n(rst_n),
        .cmd_start(cmd_start), .cmd_len(cmd_len), .cmd_busy(cmd_busy), .cmd_done(cmd_done), .cmd_err(cmd_err),
        .coef_addr(coef_addr), .coef_data(coef_data),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wvalid(wvalid), .wready(wready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .src_tvalid(src_tvalid), .src_tdata(src_tdata), .src_tready(src_tready),
        .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast), .ss_tready(ss_tready),
        .sm_tvalid(sm_tvalid), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast), .sm_tready(sm_tready),
        .dst_tvalid(dst_tvalid), .dst_tdata(dst_tdata), .dst_tlast(dst_tlast), .dst_tready(dst_tready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // AXI-Lite slave: wready first, awready AW_DELAY cycles later; ap_ctrl reads modelled.
    initial begin : slave
        int          aw_cnt;
        int          idle_left, done_left;
        logic        w_got, rd_pend, started, idle_now, done_now;
        logic [31:0] cur_wdata;
        logic [11:0] cur_awaddr, cur_araddr;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                awready = 1'b0; wready = 1'b0; arready = 1'b0; rvalid = 1'b0; rdata = 32'd0;
                w_got = 1'b0; rd_pend = 1'b0; started = 1'b0; aw_cnt = 0;
                idle_left = cfg_idle_busy; done_left = cfg_done_busy;
                wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
                rd_before_wr = -1;
            end else begin
                if (wready) begin
                    wready = 1'b0;
                end else if (wvalid && !w_got) begin
                    wready = 1'b1; w_got = 1'b1; cur_wdata = wdata; aw_cnt = 0;
                end
                if (awready) begin
                    awready = 1'b0;
                    wr_addr_q.push_back(cur_awaddr);
                    wr_data_q.push_back(cur_wdata);
                    if (wr_addr_q.size() == 1) rd_before_wr = rd_addr_q.size();
                    if (cur_awaddr == 12'h000 && cur_wdata[0]) started = 1'b1;
                    w_got = 1'b0;
                end else if (awvalid && w_got && !wready) begin
                    if (aw_cnt >= AW_DELAY) begin
                        awready = 1'b1; cur_awaddr = awaddr;
                    end else begin
                        aw_cnt++;
                    end
                end
                if (rvalid) begin
                    rvalid = 1'b0; rdata = 32'd0;
                end else if (arready) begin
                    arready = 1'b0; rd_addr_q.push_back(cur_araddr); rd_pend = 1'b1;
                end else if (rd_pend && rready) begin
                    idle_now = (idle_left == 0);
                    if (idle_left > 0) idle_left--;
                    done_now = started && (done_left == 0);
                    if (started && done_left > 0) done_left--;
                    rdata = (cur_araddr == 12'h000) ? {29'd0, idle_now, done_now, 1'b0} : 32'd0;
                    rvalid = 1'b1; rd_pend = 1'b0;
                end else if (arvalid && !rd_pend) begin
                    arready = 1'b1; cur_araddr = araddr;
                end
            end
        end
    end

    // Sample source, FIR core (output = 3*input, in order) and result sink with random stalls.
    initial begin : stream
        int          src_idx;
        logic [31:0] smq[$];
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                src_idx = 0; smq.delete(); ss_q.delete(); dst_q.delete();
                ss_last_mask = 0; dst_last_mask = 0;
                src_tvalid = 1'b0; src_tdata = 32'd0; ss_tready = 1'b0;
                sm_tvalid = 1'b0; sm_tdata = 32'd0; sm_tlast = 1'b0; dst_tready = 1'b0;
            end else begin
                src_tvalid = (src_idx < cfg_src_n) && ($urandom_range(0, 3) != 0);
                src_tdata  = src_tvalid ? 32'(src_idx + 1) : 32'd0;
                ss_tready  = ($urandom_range(0, 3) != 0);
                sm_tvalid  = (smq.size() > 0) && ($urandom_range(0, 3) != 0);
                sm_tdata   = sm_tvalid ? smq[0] : 32'd0;
                sm_tlast   = sm_tvalid && (smq.size() == 1);
                dst_tready = ($urandom_range(0, 3) != 0);
                #1;
                if (src_tvalid && src_tready) src_idx++;
                if (sm_tvalid && sm_tready) void'(smq.pop_front());
                if (ss_tvalid && ss_tready) begin
                    ss_last_mask |= 32'(ss_tlast) << ss_q.size();
                    ss_q.push_back(ss_tdata);
                    smq.push_back(ss_tdata * 3);
                end
                if (dst_tvalid && dst_tready) begin
                    dst_last_mask |= 32'(dst_tlast) << dst_q.size();
                    dst_q.push_back(dst_tdata);
                end
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                done_cnt = 0; err_cnt = 0; bus_seen = 1'b0;
            end else begin
                if (cmd_done) done_cnt++;
                if (cmd_err) err_cnt++;
                if (awvalid || wvalid || arvalid) bus_seen = 1'b1;
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_done(input string tag);
        for (int n = 0; n < 4000 && done_cnt == 0; n++) @(negedge clk);
        chk(tag, 32'(done_cnt > 0), 32'd1);
        repeat (30) @(negedge clk);
    endtask

    initial begin : main
        logic [11:0] ea;
        logic [31:0] ed;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_ctrl_out", {22'd0, cmd_busy, cmd_done, cmd_err, awvalid, wvalid, arvalid, rready, src_tready, sm_tready, ss_tvalid}, 32'd0);
        chk("reset_dst_out", {29'd0, dst_tvalid, dst_tlast, ss_tlast}, 32'd0);
        chk("reset_coef_addr", {28'd0, coef_addr}, 32'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Zero-length command is rejected
        cmd_len = 32'd0; cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
        chk("len0_err_pulse", {31'd0, cmd_err}, 32'd1);
        chk("len0_not_busy", {31'd0, cmd_busy}, 32'd0);
        @(negedge clk);
        chk("len0_err_drop", {31'd0, cmd_err}, 32'd0);
        repeat (10) @(negedge clk);
        chk("len0_err_count", 32'(err_cnt), 32'd1);
        chk("len0_no_bus", {31'd0, bus_seen}, 32'd0);

        // Job: len 8, three busy idle polls, two not-done polls, stray start mid-stream
        cfg_idle_busy = 3; cfg_done_busy = 2; cfg_src_n = 8;
        do_reset();
        cmd_len = 32'd8; cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
        chk("job1_busy", {31'd0, cmd_busy}, 32'd1);
        for (int n = 0; n < 4000 && ss_q.size() < 3; n++) @(negedge clk);
        chk("job1_reach_stream", 32'(ss_q.size() >= 3), 32'd1);
        cmd_len = 32'd5; cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
        chk("job1_busy_after_stray", {31'd0, cmd_busy}, 32'd1);
        wait_done("job1_done_seen");
        chk("job1_done_once", 32'(done_cnt), 32'd1);
        chk("job1_idle_after", {31'd0, cmd_busy}, 32'd0);
        chk("job1_reads_before_wr", 32'(rd_before_wr), 32'd4);
        chk("job1_total_reads", 32'(rd_addr_q.size()), 32'd7);
        chk("job1_write_count", 32'(wr_addr_q.size()), 32'd13);
        for (int i = 0; i < wr_addr_q.size() && i < 13; i++) begin
            ea = (i == 0) ? 12'h010 : (i == 12) ? 12'h000 : 12'(32'h40 + 4 * (i - 1));
            ed = (i == 0) ? 32'd8   : (i == 12) ? 32'd1   : 32'(32'h100 + (i - 1));
            chk($sformatf("job1_wr%0d_addr", i), {20'd0, wr_addr_q[i]}, {20'd0, ea});
            chk($sformatf("job1_wr%0d_data", i), wr_data_q[i], ed);
        end
        chk("job1_ss_count", 32'(ss_q.size()), 32'd8);
        chk("job1_ss_last", 32'(ss_last_mask), 32'h80);
        for (int i = 0; i < ss_q.size() && i < 8; i++)
            chk($sformatf("job1_ss%0d", i), ss_q[i], 32'(i + 1));
        chk("job1_dst_count", 32'(dst_q.size()), 32'd8);
        chk("job1_dst_last", 32'(dst_last_mask), 32'h80);
        for (int i = 0; i < dst_q.size() && i < 8; i++)
            chk($sformatf("job1_dst%0d", i), dst_q[i], 32'(3 * (i + 1)));

        // Reset in the middle of the tap-5 write, then a fresh len-4 job
        cfg_idle_busy = 0; cfg_done_busy = 0; cfg_src_n = 8;
        do_reset();
        cmd_len = 32'd8; cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
        for (int n = 0; n < 2000 && !(awvalid && awaddr == 12'h054); n++) @(negedge clk);
        chk("tap5_reached", {31'd0, awvalid}, 32'd1);
        chk("tap5_coef_addr", {28'd0, coef_addr}, 32'd5);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ctrl_out", {22'd0, cmd_busy, cmd_done, cmd_err, awvalid, wvalid, arvalid, rready, src_tready, sm_tready, ss_tvalid}, 32'd0);
        chk("midrst_awaddr", {20'd0, awaddr}, 32'd0);
        chk("midrst_wdata", wdata, 32'd0);
        chk("midrst_coef_addr", {28'd0, coef_addr}, 32'd0);
        cfg_done_busy = 1; cfg_src_n = 4;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        cmd_len = 32'd4; cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
        wait_done("job2_done_seen");
        chk("job2_done_once", 32'(done_cnt), 32'd1);
        chk("job2_reads_before_wr", 32'(rd_before_wr), 32'd1);
        chk("job2_first_read_addr", (rd_addr_q.size() > 0) ? {20'd0, rd_addr_q[0]} : 32'hffff_ffff, 32'd0);
        chk("job2_write_count", 32'(wr_addr_q.size()), 32'd13);
        if (wr_addr_q.size() == 13) begin
            chk("job2_len_addr", {20'd0, wr_addr_q[0]}, 32'h10);
            chk("job2_len_data", wr_data_q[0], 32'd4);
            chk("job2_start_addr", {20'd0, wr_addr_q[12]}, 32'h00);
            chk("job2_start_data", wr_data_q[12], 32'd1);
        end
        chk("job2_ss_count", 32'(ss_q.size()), 32'd4);
        chk("job2_ss_last", 32'(ss_last_mask), 32'h8);
        chk("job2_dst_count", 32'(dst_q.size()), 32'd4);
        chk("job2_dst_last", 32'(dst_last_mask), 32'h8);
        chk("job2_dst3", (dst_q.size() == 4) ? dst_q[3] : 32'hffff_ffff, 32'd12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
